// File: rtl/sync_down_counter.sv
// Synchronous loadable down counter with a one-cycle registered terminal-count pulse.
// Define SYNC_DOWN_COUNTER_AUTO_RELOAD_EN to reload from the last loaded value on each wrap.
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] QBar,
  output logic             busy,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = 1'b0;
    tc_d    = 1'b0;
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    // Load beats enable in every state; a zero load parks the counter without a pulse.
    if (load) begin
      count_d = load_val;
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_d = load_val;
`endif
      if (load_val != '0) begin
        state_d = RUN;
        busy_d  = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          busy_d = 1'b1;
          if (en) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else begin
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
              count_d = reload_q;
              tc_d    = 1'b1;
`else
              count_d = '0;
              state_d = DONE;
              busy_d  = 1'b0;
              tc_d    = 1'b1;
`endif
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count = count_q;
  assign QBar  = ~count_q;
  assign busy  = busy_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_sync_down_counter.sv
// Scoreboard bench for sync_down_counter: stimulus queues expected outputs, a monitor checks them.
module tb_sync_down_counter;
  localparam int W = 4;

  logic         Clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count, QBar;
  logic         busy, tc;

  typedef struct {
    logic [W-1:0] cnt;
    logic         busy;
    logic         tc;
    int           idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec = 0;

  sync_down_counter #(.WIDTH(W)) dut (
    .Clk(Clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
    .count(count), .QBar(QBar), .busy(busy), .tc(tc)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int idx, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, req);
    end
  endtask

  // One clock edge of stimulus; expected values are those visible after that edge.
  task automatic step(input logic l, input logic [W-1:0] lv, input logic e,
                      input logic [W-1:0] ec, input logic eb, input logic et);
    @(negedge Clk);
    load     = l;
    load_val = lv;
    en       = e;
    exp_q.push_back('{ec, eb, et, vec});
    vec++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("vec %0d: count=%h QBar=%h busy=%b tc=%b (exp count=%h busy=%b tc=%b)",
                 e.idx, count, QBar, busy, tc, e.cnt, e.busy, e.tc);
        check("count", e.idx, count, e.cnt);
        check("qbar", e.idx, QBar, ~e.cnt);
        check("busy", e.idx, W'(busy), W'(e.busy));
        check("tc", e.idx, W'(tc), W'(e.tc));
      end
    end
  end

  task automatic reset_checks(input int tag);
    check("rst_count", tag, count, 4'h0);
    check("rst_qbar", tag, QBar, 4'hF);
    check("rst_busy", tag, W'(busy), W'(1'b0));
    check("rst_tc", tag, W'(tc), W'(1'b0));
  endtask

  initial begin : stimulus
    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1 reset_checks(-1);
    @(negedge Clk);
    rst = 1'b0;

`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
    // Load 3 then nine enabled cycles: 2,1,3(tc),2,1,3(tc),2,1,3(tc).
    step(1'b1, 4'd3, 1'b0, 4'd3, 1'b1, 1'b0);
    for (int k = 1; k <= 9; k++)
      step(1'b0, 4'd0, 1'b1, W'(3 - (k % 3)), 1'b1, (k % 3) == 0);
    // Mid-run load replaces the reload value.
    step(1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd1, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd2, 1'b1, 1'b1);
    step(1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
`else
    // Basic countdown from 5.
    step(1'b1, 4'd5, 1'b0, 4'd5, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd4, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd2, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd1, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
    // Enable gaps stretch the time but not the count.
    step(1'b1, 4'd3, 1'b0, 4'd3, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd2, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd1, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    // Load mid-run with en=1: load wins, no decrement.
    step(1'b1, 4'd5, 1'b0, 4'd5, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd4, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd2, 1'b1, 1'b0);
    step(1'b1, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd8, 1'b1, 1'b0);
    // Load during DONE: tc still seen, then the new run starts.
    step(1'b1, 4'd2, 1'b0, 4'd2, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd1, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b0);
    // Maximum load value runs the full 15 enabled cycles.
    step(1'b1, 4'd15, 1'b0, 4'd15, 1'b1, 1'b0);
    for (int k = 1; k <= 14; k++)
      step(1'b0, 4'd0, 1'b1, W'(15 - k), 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
`endif
    // Zero load parks in IDLE without a pulse; en is ignored afterwards.
    step(1'b1, 4'd6, 1'b0, 4'd6, 1'b1, 1'b0);
    step(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);

    // Reset mid-run aborts immediately, between edges.
    step(1'b1, 4'd7, 1'b0, 4'd7, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd6, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd5, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 4'd4, 1'b1, 1'b0);
    @(negedge Clk);
    load = 1'b0;
    en   = 1'b1;
    #1 rst = 1'b1;
    #1 reset_checks(-2);
    repeat (2) begin
      @(negedge Clk);
      reset_checks(-3);
    end
    rst = 1'b0;
    en  = 1'b0;
    step(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge Clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
